backlight_frame_writer: RTL and testbench
=========================================

Name: backlight_frame_writer

Overview:
Parametrised successor to the single-mode zone writer for the MiniLED backlight driver. Holds per-zone luminance in a ping-pong buffer filled from the single system clock domain, so frames are tear-free. Once per refresh period it emits an sdbpflag pulse, then a burst of (address, data) writes to the LED driver RAM. Drive data is computed by a frame-latched mode and brightness setting.

Parameters:
NUM_ZONES, 360, number of LED zones; burst length
LUMA_W, 8, zone luminance width
DATA_W, 16, driver RAM data width; must be >= LUMA_W+8
PERIOD, 420000, clk cycles per refresh period; must be > BURST_START+NUM_ZONES+2
INIT_CYCLES, 2500, post-reset wait for driver register configuration
FLAG_HIGH, 30, last period-counter value at which sdbpflag is high
BURST_START, 4, period-counter value preceding the first burst write
GROUP, 24, zone group size for split mode; must be even

Ports:
clk  in  1  system clock (25 MHz)
rst_n  in  1  reset, asynchronous, active-low
zone_wr_en  in  1  write zone_wr_data into back buffer
zone_wr_addr  in  AW=$clog2(NUM_ZONES)  zone index
zone_wr_data  in  LUMA_W  zone luminance
zone_frame_done  in  1  one-cycle pulse: back buffer complete, request swap
mode_selector  in  2  00 uniform, 01 split, 10 local dimming, 11 raw
I_bright  in  8  global brightness
sdbpflag  out  1  driver frame-start flag
wtaddr  out  AW  driver RAM write address
wtdina  out  DATA_W  driver RAM write data
wt_valid  out  1  high on each burst write cycle
swap_pending  out  1  swap requested, not yet performed

Behaviour:
- Reset: all outputs 0. Init counter, period counter, swap_pending, front_valid and filter_primed cleared. Assertion mid-burst aborts immediately; after release the init wait restarts.
- Init: counter runs 0..INIT_CYCLES. ready is set when it reaches INIT_CYCLES and holds until reset. No sdbpflag, swap or burst occurs before ready.
- Period counter pc runs 0..PERIOD-1 and wraps. It runs freely from reset.
- sdbpflag: high while ready and pc in 1..FLAG_HIGH, registered. It is 0 otherwise.
- Frame latch (pc==0 and ready):
  - mode_selector and I_bright are sampled into mode_q and bright_q. They are held for the whole period, so mid-period input changes have no effect until the next pc==0.
- Swap (pc==0, ready, swap_pending):
  - Front and back buffers exchange.
  - front_valid is set.
  - swap_pending is cleared, unless zone_frame_done is high in the same cycle, in which case it stays set.
  - No data is copied; the new back buffer holds stale data.
- Swap requests: zone_frame_done sets swap_pending. Repeated pulses before a swap merge into one request.
- Back-buffer writes: writes on zone_wr_en are always accepted, including during a burst. Writes with zone_wr_addr >= NUM_ZONES are ignored.
- Burst timing:
  - For i = 0..NUM_ZONES-1, in the cycle where pc == BURST_START+1+i: wt_valid=1, wtaddr=i, wtdina=f(i).
  - Outputs are registered: the front-buffer read is issued one cycle earlier, giving 1-cycle read latency.
  - Outside the burst, wt_valid, wtaddr and wtdina are 0.
- Luminance input to f: L = front[i] when front_valid, else 0.
- f(i) by mode_q:
  - 00 uniform: 0xE0*bright_q.
  - 01 split: if (i mod GROUP) < GROUP/2 then 0xE0<<8, else L<<8.
  - 10 local dimming: L*bright_q.
  - 11 raw: L<<(DATA_W-LUMA_W).
- Arithmetic: products are unsigned, computed at LUMA_W+8 bits. If a result exceeds DATA_W bits it saturates to all-ones; otherwise it is zero-extended.

Optional Feature:
BACKLIGHT_TEMPORAL_FILTER_EN
- Defined:
  - A filter array F[NUM_ZONES] is added.
  - During the burst, L is replaced by Lf = (F[i]+L)>>1, and F[i] is written with Lf in the same burst slot (read-modify-write, no extra latency).
  - On the first burst after front_valid rises, F[i]=L and Lf=L; filter_primed is then set.
  - F is not reset; filter_primed guards it.
- Undefined: no F array, L is used directly, filter_primed is absent.

Test Plan:
- Bench parameters: PERIOD=1000, NUM_ZONES=48, INIT_CYCLES=20, GROUP=24.
- Reset release -> no sdbpflag before cycle 20; first ready period has sdbpflag high for pc 1..30; wt_valid high for pc 5..52 with wtaddr 0..47, then low.
- Mode 00, I_bright=0xFF, no swap yet -> every zone wtdina=0xDF20. Change I_bright mid-period -> value unchanged until the next pc==0.
- Fill zone 5=0x80 and pulse zone_frame_done; mode 10, I_bright=0x40 -> next period zone 5 wtdina=0x2000. Before the swap -> 0x0000.
- Mode 01, zone 30 luma=0x11, zone 12 luma=0x55 after swap -> wtdina at addr 30=0xE000, at addr 12=0x5500.
- Write zone 7 during burst, with zone_frame_done coincident with swap -> current burst unaffected, swap_pending stays 1, second swap occurs the following period. Write to addr 60 -> ignored.
- With BACKLIGHT_TEMPORAL_FILTER_EN: zone 5 = 0x80 then 0x00 on successive swaps, mode 11 -> wtdina 0x8000, 0x4000, 0x2000. Without the macro -> 0x8000, 0x0000.

Source files
------------

// File: rtl/backlight_frame_writer.sv
// ---------------------------------------------------------------------------
// backlight_frame_writer
//
// Purpose:
//   Per-zone luminance frame writer for the MiniLED backlight driver. Zone
//   luminance is written into the back half of a ping-pong buffer. Once per
//   refresh period the writer raises sdbpflag and then streams one
//   (address, data) write per zone into the LED driver RAM. Drive data is
//   derived from the front buffer and a per-frame latched mode/brightness.
//
// Optional feature (macro BACKLIGHT_TEMPORAL_FILTER_EN):
//   When defined, each zone's luminance is averaged with the previously
//   emitted filtered value (F[i]) before the drive function is applied.
//   When undefined, the front-buffer luminance is used directly.
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   zone_wr_en       write strobe for the back buffer
//   zone_wr_addr     zone index (writes at or beyond NUM_ZONES are dropped)
//   zone_wr_data     zone luminance
//   zone_frame_done  one-cycle pulse requesting a buffer swap
//   mode_selector    00 uniform, 01 split, 10 local dimming, 11 raw
//   I_bright         global brightness
//   sdbpflag         driver frame-start flag
//   wtaddr           driver RAM write address
//   wtdina           driver RAM write data
//   wt_valid         qualifies wtaddr/wtdina
//   swap_pending     a swap has been requested and not yet performed
//
// Handshake: wt_valid is a push-only strobe. The driver RAM has no back
// pressure; every cycle with wt_valid=1 carries exactly one write, and
// wtaddr/wtdina are forced to zero whenever wt_valid=0.
// ---------------------------------------------------------------------------
module backlight_frame_writer #(
    parameter int NUM_ZONES   = 360,
    parameter int LUMA_W      = 8,
    parameter int DATA_W      = 16,
    parameter int PERIOD      = 420000,
    parameter int INIT_CYCLES = 2500,
    parameter int FLAG_HIGH   = 30,
    parameter int BURST_START = 4,
    parameter int GROUP       = 24
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         zone_wr_en,
    input  logic [$clog2(NUM_ZONES)-1:0] zone_wr_addr,
    input  logic [LUMA_W-1:0]            zone_wr_data,
    input  logic                         zone_frame_done,
    input  logic [1:0]                   mode_selector,
    input  logic [7:0]                   I_bright,
    output logic                         sdbpflag,
    output logic [$clog2(NUM_ZONES)-1:0] wtaddr,
    output logic [DATA_W-1:0]            wtdina,
    output logic                         wt_valid,
    output logic                         swap_pending
);

    localparam int AW  = $clog2(NUM_ZONES);
    localparam int PCW = $clog2(PERIOD);
    localparam int INW = $clog2(INIT_CYCLES + 1);
    localparam int GW  = $clog2(GROUP);
    localparam int PW  = LUMA_W + 8;      // product width
    localparam int XW  = DATA_W + PW;     // headroom for the saturation test

    localparam logic [1:0] MODE_UNIFORM = 2'b00;
    localparam logic [1:0] MODE_SPLIT   = 2'b01;
    localparam logic [1:0] MODE_LOCAL   = 2'b10;
    localparam logic [1:0] MODE_RAW     = 2'b11;

    localparam logic [7:0] FULL_LEVEL = 8'hE0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [INW-1:0]    init_cnt;
    logic              ready;
    logic [PCW-1:0]    pc;
    logic [1:0]        mode_q;
    logic [7:0]        bright_q;
    logic              front_sel;     // 0: buf0 is front, 1: buf1 is front
    logic              front_valid;

    logic [LUMA_W-1:0] buf0 [NUM_ZONES];
    logic [LUMA_W-1:0] buf1 [NUM_ZONES];

    // Read stage: front-buffer data for the slot emitted next cycle.
    logic              rd_valid;
    logic [AW-1:0]     rd_idx;
    logic [GW-1:0]     rd_grp;
    logic [LUMA_W-1:0] rd_luma;

`ifdef BACKLIGHT_TEMPORAL_FILTER_EN
    logic [LUMA_W-1:0] filt [NUM_ZONES];
    logic [LUMA_W-1:0] rd_filt;
    logic              filter_primed;
    logic [LUMA_W:0]   filt_sum;
`endif

    // ------------------------------------------------------------------
    // Next-state helpers
    // ------------------------------------------------------------------
    logic [PCW-1:0]    pc_nxt;
    logic              ready_nxt;
    logic              frame_start;
    logic              do_swap;
    logic              wr_ok;
    logic              window_nxt;
    logic [AW-1:0]     burst_idx_nxt;
    logic              slot_fire;
    logic              flag_nxt;

    always_comb begin
        pc_nxt        = (pc == PCW'(PERIOD - 1)) ? '0 : pc + PCW'(1);
        ready_nxt     = ready | (init_cnt == INW'(INIT_CYCLES));
        frame_start   = ready && (pc == '0);
        do_swap       = frame_start && swap_pending;
        wr_ok         = zone_wr_en &&
                        ({1'b0, zone_wr_addr} < (AW+1)'(NUM_ZONES));
        // The read for slot i is issued while pc_nxt == BURST_START+i so that
        // the registered write appears at pc == BURST_START+1+i.
        window_nxt    = (pc_nxt >= PCW'(BURST_START)) &&
                        (pc_nxt <  PCW'(BURST_START + NUM_ZONES));
        burst_idx_nxt = AW'(pc_nxt - PCW'(BURST_START));
        // Gating on ready_nxt keeps the burst aligned with the cycle ready
        // becomes visible, even if that happens mid-window.
        slot_fire     = rd_valid && ready_nxt;
        flag_nxt      = ready_nxt && (pc_nxt != '0) &&
                        (pc_nxt <= PCW'(FLAG_HIGH));
    end

    // ------------------------------------------------------------------
    // Drive-data function
    // ------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] sat(input logic [PW-1:0] v);
        logic [XW-1:0] w;
        w = XW'(v);
        if (|w[XW-1:DATA_W]) sat = '1;
        else                 sat = w[DATA_W-1:0];
    endfunction

    logic [LUMA_W-1:0] luma;
    logic [LUMA_W-1:0] luma_f;
    logic              first_half;
    logic [PW-1:0]     prod_uniform;
    logic [PW-1:0]     prod_local;
    logic [PW-1:0]     split_val;
    logic [DATA_W-1:0] drive;

    always_comb begin
        luma = front_valid ? rd_luma : '0;
`ifdef BACKLIGHT_TEMPORAL_FILTER_EN
        filt_sum = {1'b0, rd_filt} + {1'b0, luma};
        // F holds garbage until the first valid frame has been emitted once.
        luma_f   = filter_primed ? filt_sum[LUMA_W:1] : luma;
`else
        luma_f   = luma;
`endif
        first_half   = rd_grp < GW'(GROUP / 2);
        prod_uniform = PW'(FULL_LEVEL) * PW'(bright_q);
        prod_local   = PW'(luma_f) * PW'(bright_q);
        split_val    = first_half ? (PW'(FULL_LEVEL) << 8) : (PW'(luma_f) << 8);
        drive        = '0;
        case (mode_q)
            MODE_UNIFORM: drive = sat(prod_uniform);
            MODE_SPLIT:   drive = sat(split_val);
            MODE_LOCAL:   drive = sat(prod_local);
            MODE_RAW:     drive = DATA_W'(luma_f) << (DATA_W - LUMA_W);
            default:      drive = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt     <= '0;
            ready        <= 1'b0;
            pc           <= '0;
            mode_q       <= '0;
            bright_q     <= '0;
            front_sel    <= 1'b0;
            front_valid  <= 1'b0;
            swap_pending <= 1'b0;
            rd_valid     <= 1'b0;
            rd_idx       <= '0;
            rd_grp       <= '0;
            sdbpflag     <= 1'b0;
            wt_valid     <= 1'b0;
            wtaddr       <= '0;
            wtdina       <= '0;
`ifdef BACKLIGHT_TEMPORAL_FILTER_EN
            filter_primed <= 1'b0;
`endif
        end else begin
            if (init_cnt != INW'(INIT_CYCLES)) init_cnt <= init_cnt + INW'(1);
            ready <= ready_nxt;
            pc    <= pc_nxt;

            if (frame_start) begin
                mode_q   <= mode_selector;
                bright_q <= I_bright;
            end

            // A done pulse coinciding with the swap is a new request for
            // the following frame, so it keeps swap_pending set.
            if (do_swap) begin
                front_sel    <= ~front_sel;
                front_valid  <= 1'b1;
                swap_pending <= zone_frame_done;
            end else if (zone_frame_done) begin
                swap_pending <= 1'b1;
            end

            rd_valid <= window_nxt;
            rd_idx   <= window_nxt ? burst_idx_nxt : '0;
            if (window_nxt) begin
                if (pc_nxt == PCW'(BURST_START) || rd_grp == GW'(GROUP - 1))
                    rd_grp <= '0;
                else
                    rd_grp <= rd_grp + GW'(1);
            end

            sdbpflag <= flag_nxt;
            wt_valid <= slot_fire;
            wtaddr   <= slot_fire ? rd_idx : '0;
            wtdina   <= slot_fire ? drive  : '0;

`ifdef BACKLIGHT_TEMPORAL_FILTER_EN
            if (slot_fire && front_valid && rd_idx == AW'(NUM_ZONES - 1))
                filter_primed <= 1'b1;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Buffer storage (no reset; validity is tracked by front_valid and
    // filter_primed)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (front_sel) buf0[zone_wr_addr] <= zone_wr_data;
            else           buf1[zone_wr_addr] <= zone_wr_data;
        end
        if (window_nxt) begin
            rd_luma <= front_sel ? buf1[burst_idx_nxt] : buf0[burst_idx_nxt];
`ifdef BACKLIGHT_TEMPORAL_FILTER_EN
            rd_filt <= filt[burst_idx_nxt];
`endif
        end
`ifdef BACKLIGHT_TEMPORAL_FILTER_EN
        // Read-modify-write of F within the same burst slot; consecutive
        // slots touch different zones, so there is no read-after-write hazard.
        if (slot_fire) filt[rd_idx] <= luma_f;
`endif
    end

endmodule

// File: tb/tb_backlight_frame_writer.sv
module tb_backlight_frame_writer;

    localparam int NZ        = 48;
    localparam int PERIOD    = 1000;
    localparam int INIT      = 20;
    localparam int GROUP     = 24;
    localparam int BS        = 4;
    localparam int FLAG_HIGH = 30;
    localparam int LUMA_W    = 8;
    localparam int DATA_W    = 16;
    localparam int AW        = 6;

    logic              clk;
    logic              rst_n;
    logic              zone_wr_en;
    logic [AW-1:0]     zone_wr_addr;
    logic [LUMA_W-1:0] zone_wr_data;
    logic              zone_frame_done;
    logic [1:0]        mode_selector;
    logic [7:0]        I_bright;
    logic              sdbpflag;
    logic [AW-1:0]     wtaddr;
    logic [DATA_W-1:0] wtdina;
    logic              wt_valid;
    logic              swap_pending;

    backlight_frame_writer #(
        .NUM_ZONES  (NZ),
        .LUMA_W     (LUMA_W),
        .DATA_W     (DATA_W),
        .PERIOD     (PERIOD),
        .INIT_CYCLES(INIT),
        .FLAG_HIGH  (FLAG_HIGH),
        .BURST_START(BS),
        .GROUP      (GROUP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .zone_wr_en     (zone_wr_en),
        .zone_wr_addr   (zone_wr_addr),
        .zone_wr_data   (zone_wr_data),
        .zone_frame_done(zone_frame_done),
        .mode_selector  (mode_selector),
        .I_bright       (I_bright),
        .sdbpflag       (sdbpflag),
        .wtaddr         (wtaddr),
        .wtdina         (wtdina),
        .wt_valid       (wt_valid),
        .swap_pending   (swap_pending)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #20 clk = ~clk;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // n_m counts clock edges since reset release; pc and ready follow from it.
    int n_m = 0;
    int sp_m = 0, fv_m = 0, mode_m = 0, bright_m = 0, primed_m = 0;
    int front_m [NZ];
    int back_m  [NZ];
    int filt_m  [NZ];

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    always @(posedge clk) begin
        logic rst_s, we_s, done_s;
        int   wa_s, wd_s, ms_s, br_s, pc_pre, pc, i, lum, d, t;
        logic rdy_pre, rdy, exp_flag, exp_v;
        int   exp_a, exp_d;
        rst_s  = rst_n;
        we_s   = zone_wr_en;
        wa_s   = int'(zone_wr_addr);
        wd_s   = int'(zone_wr_data);
        done_s = zone_frame_done;
        ms_s   = int'(mode_selector);
        br_s   = int'(I_bright);
        #1;
        exp_v = 1'b0;
        exp_a = 0;
        exp_d = 0;
        if (!rst_s) begin
            n_m = 0; sp_m = 0; fv_m = 0; mode_m = 0; bright_m = 0; primed_m = 0;
        end else begin
            pc_pre  = n_m % PERIOD;
            rdy_pre = n_m > INIT;
            if (we_s && wa_s < NZ) back_m[wa_s] = wd_s;
            if (pc_pre == 0 && rdy_pre) begin
                mode_m   = ms_s;
                bright_m = br_s;
                if (sp_m != 0) begin
                    for (int k = 0; k < NZ; k++) begin
                        t = front_m[k]; front_m[k] = back_m[k]; back_m[k] = t;
                    end
                    fv_m = 1;
                    sp_m = done_s ? 1 : 0;
                end else if (done_s) sp_m = 1;
            end else if (done_s) sp_m = 1;
            n_m++;
            pc  = n_m % PERIOD;
            rdy = n_m > INIT;
            if (rdy && pc >= BS + 1 && pc <= BS + NZ) begin
                i   = pc - BS - 1;
                lum = (fv_m != 0) ? front_m[i] : 0;
`ifdef BACKLIGHT_TEMPORAL_FILTER_EN
                lum = (primed_m != 0) ? (filt_m[i] + lum) / 2 : lum;
                filt_m[i] = lum;
                if (i == NZ - 1 && fv_m != 0) primed_m = 1;
`endif
                case (mode_m)
                    0:       d = sat16(224 * bright_m);
                    1:       d = ((i % GROUP) < GROUP / 2) ? sat16(224 * 256) : sat16(lum * 256);
                    2:       d = sat16(lum * bright_m);
                    default: d = lum * (1 << (DATA_W - LUMA_W));
                endcase
                exp_v = 1'b1;
                exp_a = i;
                exp_d = d;
            end
        end
        pc       = n_m % PERIOD;
        exp_flag = (n_m > INIT) && pc >= 1 && pc <= FLAG_HIGH;
        check("sdbpflag", 32'(sdbpflag), 32'(exp_flag));
        check("wt_valid", 32'(wt_valid), 32'(exp_v));
        check("wtaddr", 32'(wtaddr), exp_a);
        check("wtdina", 32'(wtdina), exp_d);
        check("swap_pending", 32'(swap_pending), sp_m);
    end

    // ---------------- driver tasks ----------------
    task automatic wait_pc(input int p);
        for (int k = 0; k < PERIOD + 10; k++) begin
            @(posedge clk);
            #2;
            if (n_m % PERIOD == p) return;
        end
        check("wait_pc_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        zone_wr_en   = 1'b1;
        zone_wr_addr = AW'(a);
        zone_wr_data = LUMA_W'(d);
    endtask

    task automatic idle();
        @(negedge clk);
        zone_wr_en      = 1'b0;
        zone_frame_done = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        zone_wr_en      = 1'b0;
        zone_frame_done = 1'b1;
        @(negedge clk);
        zone_frame_done = 1'b0;
    endtask

    task automatic fill_random();
        for (int z = 0; z < NZ; z++) wr(z, int'($urandom_range(0, 255)));
        idle();
    endtask

    task automatic fill_const(input int z5);
        for (int z = 0; z < NZ; z++) wr(z, (z == 5) ? z5 : 0);
        idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n           = 1'b0;
        zone_wr_en      = 1'b0;
        zone_wr_addr    = '0;
        zone_wr_data    = '0;
        zone_frame_done = 1'b0;
        mode_selector   = 2'b00;
        I_bright        = 8'hFF;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Period 0: init wait, partial first period, fill one buffer.
        wait_pc(10);
        check("flag_before_ready", 32'(sdbpflag), 32'd0);
        fill_random();

        // Period 1: uniform 0xFF, no swap yet.
        wait_pc(0);
        check("flag_pc0", 32'(sdbpflag), 32'd0);
        wait_pc(1);
        check("flag_pc1", 32'(sdbpflag), 32'd1);
        wait_pc(5);
        check("burst_first_valid", 32'(wt_valid), 32'd1);
        check("burst_first_addr", 32'(wtaddr), 32'd0);
        check("uniform_ff", 32'(wtdina), 32'hDF20);
        wait_pc(20);
        @(negedge clk);
        mode_selector = 2'b10;
        I_bright      = 8'h40;
        wait_pc(30);
        check("flag_pc30", 32'(sdbpflag), 32'd1);
        wait_pc(31);
        check("flag_pc31", 32'(sdbpflag), 32'd0);
        wait_pc(52);
        check("burst_last_addr", 32'(wtaddr), 32'd47);
        check("uniform_held", 32'(wtdina), 32'hDF20);
        wait_pc(53);
        check("burst_end_valid", 32'(wt_valid), 32'd0);
        check("burst_end_data", 32'(wtdina), 32'd0);

        // Period 2: local dimming, still no swap -> luminance reads as 0.
        wait_pc(10);
        check("local_before_swap", 32'(wtdina), 32'h0000);
        wr(5, 8'h80);
        idle();
        pulse_done();
        wait_pc(60);
        check("pending_set", 32'(swap_pending), 32'd1);

        // Period 3: swap performed; zone 5 = 0x80 * 0x40.
        wait_pc(2);
        check("pending_cleared", 32'(swap_pending), 32'd0);
        wait_pc(10);
        check("local_zone5", 32'(wtdina), 32'h2000);
        fill_random();
        wr(30, 8'h11);
        wr(12, 8'h55);
        idle();
        @(negedge clk);
        mode_selector = 2'b01;
        pulse_done();

        // Period 4: split mode, writes during the burst.
        wait_pc(8);
        wr(13, 8'h3C);
        wr(7, 8'h5A);
        wr(60, 8'h99);
        idle();
        wait_pc(17);
        check("split_addr12", 32'(wtdina), 32'h5500);
        wait_pc(35);
        check("split_addr30", 32'(wtdina), 32'hE000);
        pulse_done();
        wait_pc(0);
        @(negedge clk);
        zone_frame_done = 1'b1;
        @(negedge clk);
        zone_frame_done = 1'b0;
        wait_pc(2);
        check("pending_kept", 32'(swap_pending), 32'd1);
        wait_pc(2);
        check("second_swap", 32'(swap_pending), 32'd0);

        // Randomized phase.
        for (int c = 0; c < 5 * PERIOD; c++) begin
            @(negedge clk);
            zone_wr_en      = ($urandom_range(0, 3) == 0);
            zone_wr_addr    = AW'($urandom_range(0, 63));
            zone_wr_data    = LUMA_W'($urandom_range(0, 255));
            zone_frame_done = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 299) == 0) begin
                mode_selector = 2'($urandom_range(0, 3));
                I_bright      = 8'($urandom_range(0, 255));
            end
        end
        idle();

        // Reset in the middle of a burst.
        mode_selector = 2'b11;
        wait_pc(20);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(wt_valid), 32'd0);
        check("abort_data", 32'(wtdina), 32'd0);
        check("abort_flag", 32'(sdbpflag), 32'd0);
        check("abort_pending", 32'(swap_pending), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Raw mode: zone 5 = 0x80 then 0x00 on successive swaps.
        wait_pc(10);
        check("flag_before_ready_again", 32'(sdbpflag), 32'd0);
        wait_pc(60);
        fill_const(8'h80);
        pulse_done();
        wait_pc(10);
        check("raw_first", 32'(wtdina), 32'h8000);
        fill_const(8'h00);
        pulse_done();
        wait_pc(10);
`ifdef BACKLIGHT_TEMPORAL_FILTER_EN
        check("raw_second", 32'(wtdina), 32'h4000);
`else
        check("raw_second", 32'(wtdina), 32'h0000);
`endif
        wait_pc(10);
`ifdef BACKLIGHT_TEMPORAL_FILTER_EN
        check("raw_third", 32'(wtdina), 32'h2000);
`else
        check("raw_third", 32'(wtdina), 32'h0000);
`endif

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
